// File: rtl/ccx_emu.sv
// Chunk-serial custom-instruction emulator: latency wait, response pulse, then NCHUNK-cycle bitwise/add stream.
// Optional ADD datapath with inter-chunk carry is enabled by defining CCX_EMU_ADD_EN.
module ccx_emu #(
  parameter int unsigned CHUNKSIZE = 4,
  parameter int unsigned LATENCY   = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  input  logic [1:0]           op_i,
  input  logic [CHUNKSIZE-1:0] rs_a_i,
  input  logic [CHUNKSIZE-1:0] rs_b_i,
  output logic [CHUNKSIZE-1:0] res_o,
  output logic                 resp_o,
  output logic                 busy_o
);

  localparam int unsigned NCHUNK = 32 / CHUNKSIZE;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CHK_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(LATENCY - 1);
  localparam logic [CHK_W-1:0] LAST_CHUNK = CHK_W'(NCHUNK - 1);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_STREAM,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_lat_cnt;
  logic [CHK_W-1:0] r_chunk;
  logic [1:0]       r_op;
  logic             r_resp;
  logic             r_busy;

  logic [CHUNKSIZE-1:0] w_res;

  // Control FSM; resp/busy are registered alongside the state transitions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= '0;
      r_chunk   <= '0;
      r_op      <= OP_AND;
      r_resp    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_resp <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_i) begin
            r_state   <= S_WAIT;
            r_lat_cnt <= LAT_LOAD;
            r_busy    <= 1'b1;
            r_resp    <= 1'b0;
          end
        end
        S_WAIT: begin
          // A dropped request aborts even on the final count, so no pulse escapes.
          if (!req_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_lat_cnt == '0) begin
            r_state <= S_RESP;
            r_resp  <= 1'b1;
          end else begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_STREAM;
          r_chunk <= '0;
          r_op    <= op_i;
        end
        S_STREAM: begin
          if (r_chunk == LAST_CHUNK) begin
            r_state <= S_DONE;
            r_chunk <= '0;
          end else begin
            r_chunk <= r_chunk + CHK_W'(1);
          end
        end
        S_DONE: begin
          if (!req_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CCX_EMU_ADD_EN
  localparam int unsigned SUM_W = CHUNKSIZE + 1;

  logic             r_carry;
  logic [SUM_W-1:0] w_sum;

  assign w_sum = {1'b0, rs_a_i} + {1'b0, rs_b_i} + SUM_W'(r_carry);

  // Ripple carry between chunks; the carry out of the last chunk is simply overwritten later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_carry <= 1'b0;
    end else if (r_state == S_RESP) begin
      r_carry <= 1'b0;
    end else if (r_state == S_STREAM && r_op == OP_ADD) begin
      r_carry <= w_sum[SUM_W-1];
    end
  end
`endif

  // Result is combinational on the current chunk and forced to zero outside the stream.
  always_comb begin
    w_res = '0;
    if (r_state == S_STREAM) begin
      case (r_op)
        OP_AND:  w_res = rs_a_i & rs_b_i;
        OP_OR:   w_res = rs_a_i | rs_b_i;
        OP_XOR:  w_res = rs_a_i ^ rs_b_i;
`ifdef CCX_EMU_ADD_EN
        OP_ADD:  w_res = w_sum[CHUNKSIZE-1:0];
`else
        OP_ADD:  w_res = '0;
`endif
        default: w_res = '0;
      endcase
    end
  end

  assign res_o  = w_res;
  assign resp_o = r_resp;
  assign busy_o = r_busy;

endmodule

// File: tb/tb_ccx_emu.sv
// Directed bench for ccx_emu at CHUNKSIZE=4, LATENCY=7; ADD expectations follow CCX_EMU_ADD_EN.
module tb_ccx_emu;

  localparam int unsigned CS  = 4;
  localparam int unsigned LAT = 7;
  localparam int unsigned NCH = 8;

`ifdef CCX_EMU_ADD_EN
  localparam logic [31:0] ADD_SMALL = 32'h0000_0010;
  localparam logic [31:0] ADD_WRAP  = 32'hFFFF_FFFE;
  localparam logic [31:0] ADD_ONES  = 32'h2222_2222;
`else
  localparam logic [31:0] ADD_SMALL = 32'h0000_0000;
  localparam logic [31:0] ADD_WRAP  = 32'h0000_0000;
  localparam logic [31:0] ADD_ONES  = 32'h0000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst_i;
  logic          req_i;
  logic [1:0]    op_i;
  logic [CS-1:0] rs_a_i;
  logic [CS-1:0] rs_b_i;
  logic [CS-1:0] res_o;
  logic          resp_o;
  logic          busy_o;

  int total = 0;
  int bad   = 0;

  ccx_emu #(
    .CHUNKSIZE (CS),
    .LATENCY   (LAT)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .req_i  (req_i),
    .op_i   (op_i),
    .rs_a_i (rs_a_i),
    .rs_b_i (rs_b_i),
    .res_o  (res_o),
    .resp_o (resp_o),
    .busy_o (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_resp, input logic e_busy, input logic [CS-1:0] e_res);
    check({tag, "_resp"}, 32'(resp_o), 32'(e_resp));
    check({tag, "_busy"}, 32'(busy_o), 32'(e_busy));
    check({tag, "_res"},  32'(res_o),  32'(e_res));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full operation from IDLE; op_i is scrambled during the stream to prove it was latched.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    logic [CS-1:0] e;
    req_i  = 1'b1;
    op_i   = op;
    rs_a_i = '0;
    rs_b_i = '0;
    for (int k = 0; k <= int'(LAT + NCH); k++) begin
      step();
      e = '0;
      if (k > int'(LAT)) begin
        int j;
        j      = k - int'(LAT) - 1;
        rs_a_i = a[j*CS +: CS];
        rs_b_i = b[j*CS +: CS];
        e      = exp[j*CS +: CS];
        op_i   = ~op;
      end
      #1;
      chk_out($sformatf("%s_c%0d", tag, k), k == int'(LAT), 1'b1, e);
    end
    for (int h = 0; h < hold; h++) begin
      step();
      rs_a_i = 4'hF;
      rs_b_i = 4'hF;
      #1;
      chk_out($sformatf("%s_done%0d", tag, h), 1'b0, 1'b1, '0);
    end
    req_i = 1'b0;
    step();
    #1;
    chk_out({tag, "_idle"}, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst_i  = 1'b1;
    req_i  = 1'b0;
    op_i   = 2'b00;
    rs_a_i = '0;
    rs_b_i = '0;
    step();
    step();
    #1;
    chk_out("reset", 1'b0, 1'b0, '0);
    rst_i = 1'b0;
    step();
    #1;
    chk_out("post_reset", 1'b0, 1'b0, '0);

    // AND with a long DONE hold, then immediate restarts after a single low cycle.
    run_op("and", 2'b00, 32'hFFFF_FFFF, 32'h5555_5555, 32'h5555_5555, 20);
    run_op("or",  2'b01, 32'h1234_5678, 32'h0F0F_0F0F, 32'h1F3F_5F7F, 1);
    run_op("xor", 2'b10, 32'hA5A5_A5A5, 32'hFFFF_0000, 32'h5A5A_A5A5, 1);
    run_op("add_small", 2'b11, 32'h0000_000F, 32'h0000_0001, ADD_SMALL, 1);
    run_op("add_wrap",  2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ADD_WRAP, 2);
    run_op("add_ones",  2'b11, 32'h1111_1111, 32'h1111_1111, ADD_ONES, 1);

    // Abort while waiting: request dropped in cycle 3.
    req_i  = 1'b1;
    op_i   = 2'b00;
    rs_a_i = 4'hF;
    rs_b_i = 4'hF;
    for (int k = 0; k <= 3; k++) begin
      step();
      #1;
      chk_out($sformatf("abort_c%0d", k), 1'b0, 1'b1, '0);
    end
    req_i = 1'b0;
    for (int k = 4; k < 16; k++) begin
      step();
      #1;
      chk_out($sformatf("abort_c%0d", k), 1'b0, 1'b0, '0);
    end

    // Reset at stream chunk 4 of an ADD that keeps its carry set, with req_i still high.
    req_i  = 1'b1;
    op_i   = 2'b11;
    rs_a_i = '0;
    rs_b_i = '0;
    for (int k = 0; k <= int'(LAT) + 5; k++) begin
      step();
      if (k > int'(LAT)) begin
        rs_a_i = 4'hF;
        rs_b_i = (k == int'(LAT) + 1) ? 4'h1 : 4'h0;
      end
      #1;
      chk_out($sformatf("rst_pre_c%0d", k), k == int'(LAT), 1'b1,
              (k > int'(LAT)) ? ADD_SMALL[3:0] : 4'h0);
    end
    rst_i = 1'b1;
    step();
    #1;
    chk_out("rst_mid", 1'b0, 1'b0, '0);
    step();
    #1;
    chk_out("rst_hold_req", 1'b0, 1'b0, '0);
    rst_i = 1'b0;
    req_i = 1'b0;
    step();
    #1;
    chk_out("rst_release", 1'b0, 1'b0, '0);
    run_op("add_after_rst", 2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1);
    run_op("and_after_rst", 2'b00, 32'hC3C3_C3C3, 32'hF0F0_F0F0, 32'hC0C0_C0C0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
